// File: rtl/branch_resolve_pipe.sv
// -----------------------------------------------------------------------------
// branch_resolve_pipe
//
// Pipelined branch-resolution unit. It decodes BEQ/BNE/BLEZ/BGTZ and the
// REGIMM branches BLTZ/BGEZ/BLTZAL/BGEZAL, evaluates the branch condition,
// computes the branch target and the link address, and compares the outcome
// with the front-end prediction. Saturating counters track resolved and
// mispredicted branches.
//
// Flow control: in_valid qualifies the inputs on each rising edge. There is
// no back-pressure. An entry is accepted on an edge where in_valid=1,
// stall_i=0 and flush_i=0. out_valid qualifies the result in the last stage.
// While stall_i=1, all stages and the counters hold. flush_i has priority
// over stall_i. It clears every valid bit and drops the input presented on
// that edge.
//
// Parameters:
//   DATA_W  : operand width (sign bit is a[DATA_W-1])
//   ADDR_W  : PC / target width (modulo 2^ADDR_W arithmetic, >= 18)
//   LATENCY : 1 or 2 pipeline stages
//   CNT_W   : performance counter width
//
// Ports:
//   clk, rst              : clock (rising edge), async active-high reset
//   stall_i, flush_i      : pipeline hold / kill
//   in_valid, op, rt      : instruction valid, primary opcode, REGIMM sub-op
//   a, b                  : rs / rt operands
//   pc, imm, pred_taken   : branch PC, offset field, front-end prediction
//   out_valid             : result valid in the last stage
//   is_branch, taken      : decoded-as-branch, condition outcome
//   mispredict            : valid branch whose outcome differs from prediction
//   redirect_pc           : taken ? target : pc+8
//   link_we, link_addr    : link write for BLTZAL/BGEZAL, pc+8
//   br_count, mispred_count : saturating performance counters
// -----------------------------------------------------------------------------
module branch_resolve_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid,
  input  logic [5:0]        op,
  input  logic [4:0]        rt,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       imm,
  input  logic              pred_taken,
  output logic              out_valid,
  output logic              is_branch,
  output logic              taken,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  mispred_count
);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  typedef struct packed {
    logic              is_branch;
    logic              taken;
    logic              is_link;
    logic              pred_taken;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc8;
  } stage_t;

  // ---------------------------------------------------------------------------
  // Decode and condition evaluation (combinational, feeds stage 1)
  // ---------------------------------------------------------------------------
  logic              w_sign;
  logic              w_a_zero;
  logic              w_is_branch;
  logic              w_taken;
  logic              w_is_link;
  logic [ADDR_W-1:0] w_offset;
  stage_t            w_s1_d;

  assign w_sign   = a[DATA_W-1];
  assign w_a_zero = (a == '0);

  always_comb begin
    w_is_branch = 1'b0;
    w_taken     = 1'b0;
    w_is_link   = 1'b0;
    case (op)
      OP_BEQ:  begin w_is_branch = 1'b1; w_taken = (a == b);             end
      OP_BNE:  begin w_is_branch = 1'b1; w_taken = (a != b);             end
      OP_BLEZ: begin w_is_branch = 1'b1; w_taken = w_sign | w_a_zero;    end
      OP_BGTZ: begin w_is_branch = 1'b1; w_taken = ~w_sign & ~w_a_zero;  end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ:   begin w_is_branch = 1'b1; w_taken = w_sign;  end
          RT_BGEZ:   begin w_is_branch = 1'b1; w_taken = ~w_sign; end
          RT_BLTZAL: begin w_is_branch = 1'b1; w_taken = w_sign;  w_is_link = 1'b1; end
          RT_BGEZAL: begin w_is_branch = 1'b1; w_taken = ~w_sign; w_is_link = 1'b1; end
          default:   ;
        endcase
      end
      default: ;
    endcase
  end

  // Sign-extended word offset; wraps silently modulo 2^ADDR_W.
  assign w_offset = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};

  always_comb begin
    w_s1_d            = '0;
    w_s1_d.is_branch  = w_is_branch;
    w_s1_d.taken      = w_taken;
    w_s1_d.is_link    = w_is_link;
    w_s1_d.pred_taken = pred_taken;
    w_s1_d.target     = pc + ADDR_W'(4) + w_offset;
    w_s1_d.pc8        = pc + ADDR_W'(8);
  end

  // ---------------------------------------------------------------------------
  // Stage 1
  // ---------------------------------------------------------------------------
  logic   r_s1_valid;
  stage_t r_s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (flush_i) begin
      r_s1_valid <= 1'b0;
    end else if (!stall_i) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1 <= w_s1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional stage 2 (plain re-register of stage 1)
  // ---------------------------------------------------------------------------
  logic   w_last_valid;
  stage_t w_last;

  generate
    if (LATENCY == 2) begin : g_stage2
      logic   r_s2_valid;
      stage_t r_s2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s2_valid <= 1'b0;
          r_s2       <= '0;
        end else if (flush_i) begin
          r_s2_valid <= 1'b0;
        end else if (!stall_i) begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) r_s2 <= r_s1;
        end
      end

      assign w_last_valid = r_s2_valid;
      assign w_last       = r_s2;
    end else begin : g_stage1_only
      assign w_last_valid = r_s1_valid;
      assign w_last       = r_s1;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs from the last stage
  // ---------------------------------------------------------------------------
  logic w_mispredict;

  assign w_mispredict  = w_last_valid & w_last.is_branch & (w_last.taken != w_last.pred_taken);

  assign out_valid     = w_last_valid;
  assign is_branch     = w_last.is_branch;
  assign taken         = w_last.taken;
  assign mispredict    = w_mispredict;
  assign redirect_pc   = w_last.taken ? w_last.target : w_last.pc8;
  assign link_we       = w_last_valid & w_last.is_branch & w_last.is_link;
  assign link_addr     = w_last.pc8;

  // ---------------------------------------------------------------------------
  // Saturating performance counters. A result is counted on the edge that
  // retires it from the last stage, so a stalled result is counted once.
  // ---------------------------------------------------------------------------
  logic             w_count_en;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_mispred_count;

  assign w_count_en = w_last_valid & w_last.is_branch & ~stall_i & ~flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (w_count_en) begin
      if (r_br_count != '1)
        r_br_count <= r_br_count + 1'b1;
      if (w_mispredict && (r_mispred_count != '1))
        r_mispred_count <= r_mispred_count + 1'b1;
    end
  end

  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;

endmodule
